// File: rtl/mem_write_buffer_if.sv
// Core, fetch, RAM and halt signals of mem_write_buffer.
// master = core/RAM environment side, slave = the buffer.
interface mem_write_buffer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
);
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic              wr_req_blocked;
  logic              rd_req_valid;
  logic [TAG_W-1:0]  rd_req_tag;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_ready;
  logic              rd_resp_valid;
  logic [TAG_W-1:0]  rd_resp_tag;
  logic [DATA_W-1:0] rd_resp_data;
  logic              if_REN;
  logic [31:0]       if_addr;
  logic              if_hit;
  logic [31:0]       if_load;
  logic              ram_REN;
  logic              ram_WEN;
  logic [31:0]       ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;
  logic              halt_in;
  logic              halt_out;
  logic              DUT_error;

  modport master (
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_req_blocked,
    output rd_req_valid, rd_req_tag, rd_req_addr,
    input  rd_req_ready,
    input  rd_resp_valid, rd_resp_tag, rd_resp_data,
    output if_REN, if_addr,
    input  if_hit, if_load,
    input  ram_REN, ram_WEN, ram_addr, ram_store,
    output ram_load, ram_ready,
    output halt_in,
    input  halt_out, DUT_error
  );

  modport slave (
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_req_blocked,
    input  rd_req_valid, rd_req_tag, rd_req_addr,
    output rd_req_ready,
    output rd_resp_valid, rd_resp_tag, rd_resp_data,
    input  if_REN, if_addr,
    output if_hit, if_load,
    output ram_REN, ram_WEN, ram_addr, ram_store,
    input  ram_load, ram_ready,
    input  halt_in,
    output halt_out, DUT_error
  );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-write buffer with load forwarding and single-port RAM arbiter.
// Optional: WB_COALESCE_EN merges a write into a matching youngest entry.
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input logic CLK,
  input logic nRST,
  mem_write_buffer_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int PAD = 30 - ADDR_W;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DRAIN,
    SEL_READ,
    SEL_FETCH
  } sel_e;

  function automatic logic [31:0] baddr(
    input logic [ADDR_W-1:0] a
  );
    return {{PAD{1'b0}}, a, 2'b00};
  endfunction

  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW:0]       head_q, head_d;
  logic [PW:0]       tail_q, tail_d;
  logic              rv_q, rv_d;
  logic [TAG_W-1:0]  rt_q, rt_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;

  logic [PW-1:0]     hidx, tidx, fidx;
  logic              empty, full;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  sel_e              sel;
  logic              deq, enq, coal, err_set;
  logic              rd_rdy;

  assign hidx  = head_q[PW-1:0];
  assign tidx  = tail_q[PW-1:0];
  assign empty = (head_q == tail_q);
  assign full  = (hidx == tidx) &&
                 (head_q[PW] != tail_q[PW]);

  // Youngest valid entry matching the read address wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fidx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = hidx + PW'(i);
      if (vld_q[fidx] &&
          addr_q[fidx] == bus.rd_req_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fidx];
      end
    end
  end

  // RAM owner: full drain, unforwarded read, drain, fetch
  always_comb begin
    sel = SEL_NONE;
    if (full)
      sel = SEL_DRAIN;
    else if (bus.rd_req_valid && !fwd_hit)
      sel = SEL_READ;
    else if (!empty)
      sel = SEL_DRAIN;
    else if (bus.if_REN)
      sel = SEL_FETCH;
  end

  // Only the selected requester drives the RAM port
  always_comb begin
    bus.ram_REN  = 1'b0;
    bus.ram_WEN  = 1'b0;
    bus.ram_addr = '0;
    unique case (sel)
      SEL_DRAIN: begin
        bus.ram_WEN  = 1'b1;
        bus.ram_addr = baddr(addr_q[hidx]);
      end
      SEL_READ: begin
        bus.ram_REN  = 1'b1;
        bus.ram_addr = baddr(bus.rd_req_addr);
      end
      SEL_FETCH: begin
        bus.ram_REN  = 1'b1;
        bus.ram_addr = bus.if_addr;
      end
      default: ;
    endcase
  end

`ifdef WB_COALESCE_EN
  logic [PW-1:0] yidx;
  assign yidx = tidx - 1'b1;
  assign coal = bus.wr_req_valid && !empty &&
                vld_q[yidx] &&
                addr_q[yidx] == bus.wr_req_addr &&
                !(deq && yidx == hidx);
`else
  assign coal = 1'b0;
`endif

  assign deq     = (sel == SEL_DRAIN) && bus.ram_ready;
  assign enq     = bus.wr_req_valid && !full && !coal;
  assign err_set = bus.wr_req_valid && full && !coal;
  assign rd_rdy  = bus.rd_req_valid &&
                   (fwd_hit ||
                    (sel == SEL_READ && bus.ram_ready));

  assign bus.ram_store      = data_q[hidx];
  assign bus.if_load        = bus.ram_load;
  assign bus.if_hit         = (sel == SEL_FETCH) &&
                              bus.ram_ready;
  assign bus.rd_req_ready   = rd_rdy;
  assign bus.wr_req_blocked = full;
  assign bus.halt_out       = bus.halt_in && empty;
  assign bus.rd_resp_valid  = rv_q;
  assign bus.rd_resp_tag    = rt_q;
  assign bus.rd_resp_data   = rd_q;
  assign bus.DUT_error      = err_q;

  // Next-state for pointers, response and error flag
  always_comb begin
    head_d = head_q + (PW+1)'(deq);
    tail_d = tail_q + (PW+1)'(enq);
    rv_d   = rd_rdy;
    rt_d   = rt_q;
    rd_d   = rd_q;
    if (rd_rdy) begin
      rt_d = bus.rd_req_tag;
      rd_d = fwd_hit ? fwd_data : bus.ram_load;
    end
    err_d  = err_q | err_set;
  end

  // Pointer, response and error registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
      rv_q   <= 1'b0;
      rt_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      rv_q   <= rv_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end

  // Entry storage: retire at head, allocate at tail
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (deq)
        vld_q[hidx] <= 1'b0;
      if (enq) begin
        vld_q[tidx]  <= 1'b1;
        addr_q[tidx] <= bus.wr_req_addr;
        data_q[tidx] <= bus.wr_req_data;
      end
`ifdef WB_COALESCE_EN
      if (coal)
        data_q[yidx] <= bus.wr_req_data;
`endif
    end
  end
endmodule
